// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronizes and debounces raw coin levels into clean rs5/rs10/reject pulses with jam detection.
// Optional build macro COIN_TALLY_EN adds tally_clr, tally5 and tally10 accepted-coin counters.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
`ifdef COIN_TALLY_EN
    input  logic       tally_clr,
    output logic [7:0] tally5,
    output logic [7:0] tally10,
`endif
    output logic       rs5,
    output logic       rs10,
    output logic       coin_reject,
    output logic       jam
);

    localparam int CW = $clog2(JAM_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] JAM_LAST = CW'(JAM_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUALIFY = 3'd1,
        ST_EMIT    = 3'd2,
        ST_REJ     = 3'd3,
        ST_RELEASE = 3'd4,
        ST_JAM     = 3'd5
    } state_e;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [1:0]    sync5_r;
    logic [1:0]    sync10_r;
    logic [1:0]    s_s;
    state_e        state_r;
    logic [1:0]    code_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] jam_cnt_r;
    logic          rs5_r;
    logic          rs10_r;
    logic          reject_r;
    logic          jam_r;

    // Two-flop synchronizers for the asynchronous sensor levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync5_r  <= 2'b00;
            sync10_r <= 2'b00;
        end else begin
            sync5_r  <= {sync5_r[0], coin5_raw};
            sync10_r <= {sync10_r[0], coin10_raw};
        end
    end

    assign s_s = {sync10_r[1], sync5_r[1]};

    // Qualification FSM; outputs are registered alongside the state they decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            code_r    <= 2'b00;
            cnt_r     <= CNT_ZERO;
            jam_cnt_r <= CNT_ZERO;
            rs5_r     <= 1'b0;
            rs10_r    <= 1'b0;
            reject_r  <= 1'b0;
            jam_r     <= 1'b0;
        end else begin
            rs5_r    <= 1'b0;
            rs10_r   <= 1'b0;
            reject_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (s_s != 2'b00) begin
                        code_r  <= s_s;
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    if (s_s == 2'b00) begin
                        state_r <= ST_IDLE;
                    end else if (s_s != code_r) begin
                        code_r <= s_s;
                        cnt_r  <= CNT_ZERO;
                    end else if (cnt_r == DEB_LAST) begin
                        if (code_r == 2'b11) begin
                            state_r  <= ST_REJ;
                            reject_r <= 1'b1;
                        end else begin
                            state_r <= ST_EMIT;
                            rs5_r   <= (code_r == 2'b01);
                            rs10_r  <= (code_r == 2'b10);
                        end
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                ST_EMIT, ST_REJ: begin
                    state_r   <= ST_RELEASE;
                    cnt_r     <= CNT_ZERO;
                    jam_cnt_r <= CNT_ZERO;
                end
                ST_RELEASE: begin
                    // cnt_r tracks consecutive clear samples; jam_cnt_r accumulates active ones.
                    if (s_s != 2'b00) begin
                        cnt_r <= CNT_ZERO;
                        if (jam_cnt_r == JAM_LAST) begin
                            state_r <= ST_JAM;
                            jam_r   <= 1'b1;
                        end else begin
                            jam_cnt_r <= sat_inc(jam_cnt_r);
                        end
                    end else if (cnt_r == DEB_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                ST_JAM: begin
                    if (s_s != 2'b00) begin
                        cnt_r <= CNT_ZERO;
                    end else if (cnt_r == DEB_LAST) begin
                        state_r <= ST_IDLE;
                        jam_r   <= 1'b0;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    code_r    <= 2'b00;
                    cnt_r     <= CNT_ZERO;
                    jam_cnt_r <= CNT_ZERO;
                    jam_r     <= 1'b0;
                end
            endcase
        end
    end

    assign rs5         = rs5_r;
    assign rs10        = rs10_r;
    assign coin_reject = reject_r;
    assign jam         = jam_r;

`ifdef COIN_TALLY_EN
    logic [7:0] tally5_r;
    logic [7:0] tally10_r;

    // Accepted-coin tallies; clear wins over a same-cycle increment, counts hold at 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tally5_r  <= 8'd0;
            tally10_r <= 8'd0;
        end else if (tally_clr) begin
            tally5_r  <= 8'd0;
            tally10_r <= 8'd0;
        end else begin
            if (rs5_r && (tally5_r != 8'hff)) begin
                tally5_r <= tally5_r + 8'd1;
            end
            if (rs10_r && (tally10_r != 8'hff)) begin
                tally10_r <= tally10_r + 8'd1;
            end
        end
    end

    assign tally5  = tally5_r;
    assign tally10 = tally10_r;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: directed coin sequences push timed expectations, a negedge monitor checks them.
module tb_coin_acceptor;

    logic clk;
    logic reset;
    logic coin5_raw;
    logic coin10_raw;
    logic rs5;
    logic rs10;
    logic coin_reject;
    logic jam;
`ifdef COIN_TALLY_EN
    logic       tally_clr;
    logic [7:0] tally5;
    logic [7:0] tally10;
`endif

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .JAM_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
`ifdef COIN_TALLY_EN
        .tally_clr  (tally_clr),
        .tally5     (tally5),
        .tally10    (tally10),
`endif
        .rs5        (rs5),
        .rs10       (rs10),
        .coin_reject(coin_reject),
        .jam        (jam)
    );

    typedef enum logic [2:0] {
        EV_RS5, EV_RS10, EV_REJ, EV_JAM_RISE, EV_JAM_FALL, EV_QUIET, EV_TALLY5
    } ev_e;

    typedef struct {
        ev_e kind;
        int  cyc;
        int  val;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    logic jam_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input ev_e kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Monitor: every output event must match the head of the scoreboard at the predicted cycle.
    always @(negedge clk) begin
        ev_t e;
        ev_e got;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got nothing, required %s at cycle %0d", e.kind.name(), e.cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == EV_QUIET) begin
            e = exp_q.pop_front();
            vectors++;
            if ({rs5, rs10, coin_reject, jam} !== 4'b0000) begin
                miscompares++;
                $display("FAIL quiet_outputs@%0d: rs5/rs10/reject/jam got %b required 0000",
                         cyc, {rs5, rs10, coin_reject, jam});
            end
        end
`ifdef COIN_TALLY_EN
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == EV_TALLY5) begin
            e = exp_q.pop_front();
            vectors++;
            if (tally5 !== 8'(e.val)) begin
                miscompares++;
                $display("FAIL tally5@%0d: got %0d required %0d", cyc, tally5, e.val);
            end
        end
`endif
        if (rs5 || rs10 || coin_reject) begin
            vectors++;
            if ((32'(rs5) + 32'(rs10) + 32'(coin_reject)) > 32'd1) begin
                miscompares++;
                $display("FAIL pulse_onehot@%0d: got rs5/rs10/reject %b required at most one high",
                         cyc, {rs5, rs10, coin_reject});
            end
            got = rs5 ? EV_RS5 : (rs10 ? EV_RS10 : EV_REJ);
            vectors++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == got) begin
                e = exp_q.pop_front();
            end else begin
                miscompares++;
                $display("FAIL unexpected_pulse@%0d: got %s, required %s", cyc, got.name(),
                         (exp_q.size() > 0) ? exp_q[0].kind.name() : "none");
            end
        end
        if (jam !== jam_prev) begin
            got = jam ? EV_JAM_RISE : EV_JAM_FALL;
            vectors++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == got) begin
                e = exp_q.pop_front();
            end else begin
                miscompares++;
                $display("FAIL unexpected_jam_edge@%0d: got %s, required %s", cyc, got.name(),
                         (exp_q.size() > 0) ? exp_q[0].kind.name() : "none");
            end
        end
        jam_prev = jam;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Single coin: level rises before edge k, rs5/rs10 expected after edge k+6.
    task automatic coin(input logic c5, input logic c10, input int hold);
        int k;
        @(negedge clk);
        coin5_raw  = c5;
        coin10_raw = c10;
        k = cyc + 1;
        if (c5 && c10)
            expect_at(EV_REJ, k + 6, 0);
        else if (c5)
            expect_at(EV_RS5, k + 6, 0);
        else
            expect_at(EV_RS10, k + 6, 0);
        idle(hold);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        idle(12);
    endtask

    initial begin
        int k;
        reset      = 1'b0;
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
`ifdef COIN_TALLY_EN
        tally_clr  = 1'b0;
`endif
        // Reset held: outputs must be zero; then 20 idle cycles stay quiet.
        @(negedge clk);
        expect_at(EV_QUIET, cyc + 1, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(19);
        expect_at(EV_QUIET, cyc + 1, 0);
        idle(2);

        // Clean coin5 and ambiguous both-sensor coin.
        coin(1'b1, 1'b0, 12);
        coin(1'b1, 1'b1, 8);

        // Bouncing coin10: pulse 6 cycles after the stable level starts.
        @(negedge clk); coin10_raw = 1'b1;
        @(negedge clk); coin10_raw = 1'b0;
        @(negedge clk); coin10_raw = 1'b1;
        @(negedge clk); coin10_raw = 1'b0;
        @(negedge clk); coin10_raw = 1'b1;
        expect_at(EV_RS10, cyc + 1 + 6, 0);
        idle(10);
        coin10_raw = 1'b0;
        idle(12);

        // Stuck coin5: one pulse, jam after 16 active release samples, clear 4 samples after release.
        @(negedge clk);
        coin5_raw = 1'b1;
        k = cyc + 1;
        expect_at(EV_RS5, k + 6, 0);
        expect_at(EV_JAM_RISE, k + 23, 0);
        expect_at(EV_JAM_FALL, k + 45, 0);
        idle(40);
        coin5_raw = 1'b0;
        idle(8);
        coin(1'b0, 1'b1, 8);

        // Reset during the final QUALIFY cycle aborts the coin10 pulse.
        @(negedge clk);
        coin10_raw = 1'b1;
        k = cyc + 1;
        repeat (6) @(posedge clk);
        #2;
        reset      = 1'b0;
        coin10_raw = 1'b0;
        expect_at(EV_QUIET, cyc, 0);
        idle(2);
        reset = 1'b1;
        idle(14);

`ifdef COIN_TALLY_EN
        coin(1'b1, 1'b0, 8);
        coin(1'b1, 1'b0, 8);
        coin(1'b1, 1'b0, 8);
        expect_at(EV_TALLY5, cyc + 1, 3);
        idle(2);
        tally_clr = 1'b1;
        @(negedge clk);
        tally_clr = 1'b0;
        expect_at(EV_TALLY5, cyc + 1, 0);
        idle(3);
`endif

        expect_at(EV_QUIET, cyc + 2, 0);
        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Upstream front end for the vending FSM. Converts raw, asynchronous, bouncy coin-sensor levels into clean single-cycle rs5/rs10 pulses in the clk domain, which drive the vending machine's coin inputs directly.
- Rejects coins whose code is ambiguous (both sensors active).
- Flags a jammed sensor that stays active.
- Guarantees rs5 and rs10 are never high together.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to qualify a coin or a release; must be >= 2.
JAM_CYCLES, 64, cycles in RELEASE with the sensor still active before declaring a jam; must be > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
coin5_raw  input  1  raw 5-unit coin sensor level, asynchronous to clk.
coin10_raw  input  1  raw 10-unit coin sensor level, asynchronous to clk.
rs5  output  1  one-cycle pulse: 5-unit coin accepted.
rs10  output  1  one-cycle pulse: 10-unit coin accepted.
coin_reject  output  1  one-cycle pulse: ambiguous code (both sensors) qualified.
jam  output  1  level: sensor stuck active; high while in JAM.

Behaviour:
- Synchronizer: each raw input passes through a 2-flop synchronizer. The 2-bit synchronized code is s = {s10, s5}.
- Reset (reset = 0, async):
  - Synchronizers cleared; state = IDLE; counter = 0; latched code = 00.
  - All outputs 0 immediately, not waiting for a clock edge.
- Outputs are registered Moore decodes of state:
  - rs5 = (state == EMIT && code == 01).
  - rs10 = (state == EMIT && code == 10).
  - coin_reject = (state == REJ).
  - jam = (state == JAM).
- States: IDLE, QUALIFY, EMIT, REJ, RELEASE, JAM. All transitions occur on the rising clk edge.
- IDLE:
  - s == 00: stay.
  - s != 00: latch code = s, counter = 0, go to QUALIFY.
- QUALIFY:
  - s == 00: go to IDLE (glitch discarded, no output).
  - s != code: latch new code, counter = 0, stay.
  - s == code and counter == DEBOUNCE_CYCLES-1: go to EMIT if code is 01 or 10; go to REJ if code is 11.
  - Otherwise counter++.
- EMIT / REJ: last exactly one cycle. Then go to RELEASE with counter = 0.
- RELEASE (wait for the coin to clear):
  - Every cycle with s != 00: release-stable count = 0 and jam counter increments.
  - Every cycle with s == 00: release-stable count increments.
  - Release-stable count reaches DEBOUNCE_CYCLES: go to IDLE.
  - Jam counter reaches JAM_CYCLES: go to JAM.
  - Both counters are cleared on RELEASE entry.
- JAM: jam held high. Leave to IDLE only after DEBOUNCE_CYCLES consecutive s == 00 samples; any s != 00 restarts that count.
- Latency: raw level stable before edge k gives QUALIFY at edge k+2 and EMIT at edge k+2+DEBOUNCE_CYCLES. The pulse is high for exactly one cycle.
- Pulse guarantees:
  - At most one of rs5, rs10, coin_reject is high in any cycle.
  - Minimum spacing between accepted-coin pulses is 2*DEBOUNCE_CYCLES+2 cycles.
  - A held coin never produces a second pulse.
- Simultaneous raw edges on both sensors are treated as code 11 and result in a reject. A staggered arrival restarts qualification on the new code.
- Reset mid-operation: an in-flight pulse is aborted and the coin is not counted.
- Counter width: $clog2(JAM_CYCLES+1). Counters saturate and never wrap.

Optional Feature:
Macro COIN_TALLY_EN.
- Defined, the block adds:
  - Input tally_clr (1 bit, synchronous clear).
  - Outputs tally5[7:0] and tally10[7:0].
  - tally5/tally10 increment in the cycle after rs5/rs10 is high and saturate at 255.
  - tally_clr has priority over an increment.
  - Both tallies are reset to 0 by reset.
- Undefined: these ports and registers are absent. All other behaviour is identical.

Test Plan:
- Parameters DEBOUNCE_CYCLES=4, JAM_CYCLES=16 unless noted.
1. Reset release, both raw inputs low for 20 cycles -> all outputs stay 0; state remains IDLE.
2. coin5_raw high before edge k, held 12 cycles, then low -> rs5 high exactly during cycle k+6 to k+7; rs10 and coin_reject stay 0; no second pulse.
3. coin10_raw bounce 1,0,1,0 for 1 cycle each, then held high 10 cycles -> exactly one rs10 pulse, 6 cycles after the start of the stable level.
4. coin5_raw and coin10_raw rise on the same cycle, held 8 cycles -> one coin_reject pulse; rs5 = rs10 = 0 throughout.
5. coin5_raw held high 40 cycles -> one rs5 pulse, then jam rises and stays high. Lowering the input drops jam 4 synchronized cycles later. A following coin10 is accepted normally.
6. coin10_raw qualified, with reset driven to 0 in the QUALIFY cycle before EMIT -> no rs10 pulse; all outputs 0 at once. With COIN_TALLY_EN defined: three coin5s followed by tally_clr give tally5 = 3, then 0.
